// File: rtl/instr_mem_banked_if.sv
// Fetch and loader signal bundle for the banked instruction memory.
// master = pipeline/host side, slave = memory side.
interface instr_mem_banked_if #(
  parameter int ADDR_W = 8
);
  // IF-stage fetch port
  logic [31:0]     if_addr;
  logic            if_stall;
  logic            if_flush;
  logic [31:0]     if_instr;
  logic            if_valid;
  logic            if_fault;

  // Program loader port
  logic            ld_start;
  logic            ld_bank;
  logic [ADDR_W-1:0] ld_base;
  logic            ld_valid;
  logic [31:0]     ld_data;
  logic            ld_last;
  logic            ld_ready;
  logic            ld_busy;
  logic [ADDR_W:0] ld_count;
  logic            ld_err;

  modport master (
    output if_addr, if_stall, if_flush,
    input  if_instr, if_valid, if_fault,
    output ld_start, ld_bank, ld_base, ld_valid, ld_data, ld_last,
    input  ld_ready, ld_busy, ld_count, ld_err
  );

  modport slave (
    input  if_addr, if_stall, if_flush,
    output if_instr, if_valid, if_fault,
    input  ld_start, ld_bank, ld_base, ld_valid, ld_data, ld_last,
    output ld_ready, ld_busy, ld_count, ld_err
  );
endinterface

// File: rtl/instr_mem_banked.sv
// Two-bank (user / kernel) instruction memory with a registered 1-cycle fetch
// port and a valid/ready loader that writes program words at runtime.
module instr_mem_banked #(
  parameter int          USER_DEPTH   = 256,
  parameter int          KERNEL_DEPTH = 16,
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  instr_mem_banked_if.slave bus
);

  localparam int U_AW = (USER_DEPTH > 1) ? $clog2(USER_DEPTH) : 1;
  localparam int K_AW = (KERNEL_DEPTH > 1) ? $clog2(KERNEL_DEPTH) : 1;
  localparam logic [ADDR_W:0] U_LIM = (ADDR_W + 1)'(USER_DEPTH);
  localparam logic [ADDR_W:0] K_LIM = (ADDR_W + 1)'(KERNEL_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  // NOTE: the arrays are never reset; they take NOP_WORD as their power-up
  // value so a RAM macro can be inferred and loaded words survive a reset.
  logic [31:0] user_mem   [USER_DEPTH]   = '{default: NOP_WORD};
  logic [31:0] kernel_mem [KERNEL_DEPTH] = '{default: NOP_WORD};

  state_t          state_q;
  logic            ld_bank_q;
  logic [ADDR_W:0] ptr_q;
  logic [ADDR_W:0] ld_count_q;
  logic            ld_err_q;
  logic            ld_ready_q;
  logic            ld_busy_q;

  logic [31:0]     instr_q;
  logic            valid_q;
  logic            fault_q;

  // ------------------------------------------------------------------
  // Fetch address decode
  // ------------------------------------------------------------------
  logic              f_bank;
  logic [ADDR_W-1:0] f_idx;
  logic              f_hit;
  logic [31:0]       f_word;
  logic              unused_addr_bits;

  assign f_bank = bus.if_addr[31];
  assign f_idx  = bus.if_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.if_addr[30:ADDR_W+2], bus.if_addr[1:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    f_hit  = 1'b0;
    f_word = NOP_WORD;
    if (f_bank) begin
      f_hit = ({1'b0, f_idx} < K_LIM);
      if (f_hit) f_word = kernel_mem[f_idx[K_AW-1:0]];
    end else begin
      f_hit = ({1'b0, f_idx} < U_LIM);
      if (f_hit) f_word = user_mem[f_idx[U_AW-1:0]];
    end
  end

  // ------------------------------------------------------------------
  // Loader write decode
  // ------------------------------------------------------------------
  logic xfer;
  logic wr_hit;

  assign xfer   = (state_q == S_LOAD) && bus.ld_valid && ld_ready_q;
  // ptr_q is one bit wider than an index, so a saturated pointer never hits.
  assign wr_hit = ld_bank_q ? (ptr_q < K_LIM) : (ptr_q < U_LIM);

  // Writes are suppressed on a reset edge so an aborted session stores nothing
  // beyond the words already accepted.
  always_ff @(posedge clk) begin
    if (reset && xfer && wr_hit) begin
      if (ld_bank_q) kernel_mem[ptr_q[K_AW-1:0]] <= bus.ld_data;
      else           user_mem[ptr_q[U_AW-1:0]]   <= bus.ld_data;
    end
  end

  // ------------------------------------------------------------------
  // Loader FSM with registered handshake/status outputs
  // ------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ld_bank_q  <= 1'b0;
      ptr_q      <= '0;
      ld_count_q <= '0;
      ld_err_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ld_start) begin
            state_q    <= S_LOAD;
            ld_bank_q  <= bus.ld_bank;
            ptr_q      <= {1'b0, bus.ld_base};
            ld_count_q <= '0;
            ld_err_q   <= 1'b0;
            ld_ready_q <= 1'b1;
            ld_busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            if (!wr_hit)           ld_err_q   <= 1'b1;
            if (!ptr_q[ADDR_W])    ptr_q      <= ptr_q + 1'b1;
            if (ld_count_q != '1)  ld_count_q <= ld_count_q + 1'b1;
            if (bus.ld_last) begin
              state_q    <= S_IDLE;
              ld_ready_q <= 1'b0;
              ld_busy_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Registered fetch stage: flush > stall > load-busy > normal fetch
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (bus.if_flush) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (bus.if_stall) begin
      instr_q <= instr_q;
      valid_q <= valid_q;
      fault_q <= fault_q;
    end else if (state_q == S_LOAD) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      instr_q <= f_word;
      valid_q <= 1'b1;
      fault_q <= !f_hit;
    end
  end

  assign bus.if_instr = instr_q;
  assign bus.if_valid = valid_q;
  assign bus.if_fault = fault_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_busy  = ld_busy_q;
  assign bus.ld_count = ld_count_q;
  assign bus.ld_err   = ld_err_q;

endmodule

// File: tb/tb_instr_mem_banked.sv
// Self-checking bench for instr_mem_banked: directed scenarios plus randomized
// fetch/stall/flush/load traffic against an array-based reference model.
module tb_instr_mem_banked;

  localparam int          AW    = 8;
  localparam int          UDEP  = 256;
  localparam int          KDEP  = 16;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam int          PMAX  = 1 << AW;

  logic clk = 1'b0;
  logic reset;

  instr_mem_banked_if #(.ADDR_W(AW)) bus ();

  instr_mem_banked #(
    .USER_DEPTH  (UDEP),
    .KERNEL_DEPTH(KDEP),
    .ADDR_W      (AW),
    .NOP_WORD    (NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference memory image
  logic [31:0] user_m [UDEP];
  logic [31:0] kern_m [KDEP];

  // Expected fetch result for an address, as {instr, valid, fault}
  function automatic logic [33:0] exp_fetch(input logic [31:0] a);
    int idx;
    idx = int'(a[AW+1:2]);
    if (a[31]) begin
      if (idx < KDEP) return {kern_m[idx], 1'b1, 1'b0};
      return {NOP, 1'b1, 1'b1};
    end
    if (idx < UDEP) return {user_m[idx], 1'b1, 1'b0};
    return {NOP, 1'b1, 1'b1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input string name);
    logic [33:0] exp;
    bus.if_addr  = addr;
    bus.if_stall = 1'b0;
    bus.if_flush = 1'b0;
    exp = exp_fetch(addr);
    step();
    checks++;
    if ({bus.if_instr, bus.if_valid, bus.if_fault} !== exp) begin
      errors++;
      $display("FAIL %s addr=%h: got instr/valid/fault=%h/%b/%b expected %h/%b/%b",
               name, addr, bus.if_instr, bus.if_valid, bus.if_fault,
               exp[33:2], exp[1], exp[0]);
    end
  endtask

  // One complete load session with random wait cycles and ignored ld_start pulses.
  task automatic do_load(input logic bank, input int base, input logic [31:0] words[$],
                         input int gap_max, input string name);
    int       ptr;
    int       cnt;
    logic     err;
    int       depth;
    logic [11:0] exp_ld;
    depth = bank ? KDEP : UDEP;
    bus.if_stall = 1'b0;
    bus.if_flush = 1'b0;
    bus.ld_start = 1'b1;
    bus.ld_bank  = bank;
    bus.ld_base  = AW'(base);
    step();
    bus.ld_start = 1'b0;
    // Scramble the sampled fields to show they were latched
    bus.ld_bank  = ~bank;
    bus.ld_base  = AW'($urandom);
    checks++;
    if ({bus.ld_busy, bus.ld_ready, bus.ld_count, bus.ld_err} !== {1'b1, 1'b1, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL %s start: got busy/ready/count/err=%b/%b/%0d/%b expected 1/1/0/0",
               name, bus.ld_busy, bus.ld_ready, bus.ld_count, bus.ld_err);
    end
    ptr = base;
    cnt = 0;
    err = 1'b0;
    foreach (words[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = $urandom;
        step();
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = words[i];
      bus.ld_last  = (i == words.size() - 1);
      bus.ld_start = 1'($urandom_range(1, 0));
      step();
      if (ptr < depth) begin
        if (bank) kern_m[ptr] = words[i];
        else      user_m[ptr] = words[i];
      end else begin
        err = 1'b1;
      end
      if (ptr < PMAX) ptr++;
      cnt++;
      exp_ld = {(i != words.size() - 1), (i != words.size() - 1), 9'(cnt), err};
      checks++;
      if ({bus.ld_busy, bus.ld_ready, bus.ld_count, bus.ld_err, bus.if_valid} !== {exp_ld, 1'b0}) begin
        errors++;
        $display("FAIL %s word%0d: got busy/ready/count/err/if_valid=%b/%b/%0d/%b/%b expected %b/%b/%0d/%b/0",
                 name, i, bus.ld_busy, bus.ld_ready, bus.ld_count, bus.ld_err, bus.if_valid,
                 exp_ld[11], exp_ld[10], exp_ld[9:1], exp_ld[0]);
      end
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.ld_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.if_instr, bus.if_valid, bus.if_fault} !== {NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_fetch: got %h/%b/%b expected %h/0/0",
               bus.if_instr, bus.if_valid, bus.if_fault, NOP);
    end
    checks++;
    if ({bus.ld_ready, bus.ld_busy, bus.ld_count, bus.ld_err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_loader: got ready/busy/count/err=%b/%b/%0d/%b expected 0/0/0/0",
               bus.ld_ready, bus.ld_busy, bus.ld_count, bus.ld_err);
    end
    reset = 1'b1;
    do_fetch(32'h0000_0014, "powerup_user");
    do_fetch(32'h8000_0008, "powerup_kernel");
  endtask

  task automatic test_user_load();
    logic [31:0] w[$];
    w = '{32'h2004_0003, 32'h2084_0001, 32'hAFA4_0000};
    do_load(1'b0, 0, w, 0, "user_load");
    do_fetch(32'h0000_0000, "user_fetch0");
    do_fetch(32'h0000_0004, "user_fetch1");
    do_fetch(32'h0000_0008, "user_fetch2");
  endtask

  task automatic test_kernel_load();
    logic [31:0] w[$];
    w = '{32'h0800_0006};
    do_load(1'b1, 0, w, 2, "kernel_load");
    do_fetch(32'h8000_0000, "kernel_fetch0");
    do_fetch(32'h0000_0000, "user_unchanged");
  endtask

  task automatic test_fault();
    do_fetch(32'h8000_0040, "kernel_fault16");
    do_fetch(32'h8000_003C, "kernel_last_ok");
    do_fetch(32'h8000_03FF, "kernel_fault255");
  endtask

  task automatic test_stall_flush();
    logic [33:0] held;
    do_fetch(32'h0000_0004, "pre_stall");
    held = exp_fetch(32'h0000_0004);
    bus.if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.if_addr = {1'($urandom_range(1, 0)), 31'($urandom)};
      step();
      checks++;
      if ({bus.if_instr, bus.if_valid, bus.if_fault} !== held) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h/%b/%b expected %h/%b/%b", i,
                 bus.if_instr, bus.if_valid, bus.if_fault, held[33:2], held[1], held[0]);
      end
    end
    bus.if_flush = 1'b1;
    step();
    checks++;
    if ({bus.if_instr, bus.if_valid, bus.if_fault} !== {NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stall_flush: got %h/%b/%b expected %h/0/0",
               bus.if_instr, bus.if_valid, bus.if_fault, NOP);
    end
    bus.if_flush = 1'b0;
    step();
    checks++;
    if ({bus.if_instr, bus.if_valid, bus.if_fault} !== {NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stall_after_flush: got %h/%b/%b expected %h/0/0",
               bus.if_instr, bus.if_valid, bus.if_fault, NOP);
    end
    bus.if_stall = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] w[$];
    w = '{32'hCAFE_0001, 32'hCAFE_0002};
    do_load(1'b1, 15, w, 1, "kernel_overflow");
    do_fetch(32'h8000_003C, "kernel_idx15");
    do_fetch(32'h8000_0000, "kernel_idx0_kept");
    // User pointer saturates at 2^ADDR_W: no wrap onto index 0
    w = '{32'hBEEF_00FE, 32'hBEEF_00FF, 32'hBEEF_0100, 32'hBEEF_0101};
    do_load(1'b0, 254, w, 0, "user_saturate");
    do_fetch(32'h0000_03F8, "user_idx254");
    do_fetch(32'h0000_03FC, "user_idx255");
    do_fetch(32'h0000_0000, "user_idx0_nowrap");
  endtask

  task automatic test_reset_mid_load();
    bus.ld_start = 1'b1;
    bus.ld_bank  = 1'b0;
    bus.ld_base  = AW'(20);
    step();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h1234_5678;
    bus.ld_last  = 1'b0;
    step();
    user_m[20] = 32'h1234_5678;
    bus.ld_valid = 1'b0;
    reset = 1'b0;
    step();
    checks++;
    if ({bus.ld_busy, bus.ld_ready, bus.ld_count, bus.ld_err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_load: got busy/ready/count/err=%b/%b/%0d/%b expected 0/0/0/0",
               bus.ld_busy, bus.ld_ready, bus.ld_count, bus.ld_err);
    end
    reset = 1'b1;
    do_fetch(32'h0000_0050, "mid_load_persist");
    do_fetch(32'h0000_0054, "mid_load_next");
  endtask

  task automatic test_random();
    logic [33:0] exp;
    logic [31:0] addr;
    logic [31:0] w[$];
    logic        st;
    logic        fl;
    exp = {NOP, 1'b0, 1'b0};
    bus.if_stall = 1'b0;
    bus.if_flush = 1'b0;
    step();
    exp = exp_fetch(bus.if_addr);
    for (int n = 0; n < 600; n++) begin
      if (n % 75 == 74) begin
        w.delete();
        repeat ($urandom_range(5, 1)) w.push_back($urandom);
        if ($urandom_range(1, 0) == 1) do_load(1'b1, $urandom_range(19, 0), w, 2, "rnd_load_k");
        else                           do_load(1'b0, $urandom_range(255, 0), w, 2, "rnd_load_u");
        exp = {NOP, 1'b0, 1'b0};
      end
      st   = ($urandom_range(3, 0) == 0);
      fl   = ($urandom_range(7, 0) == 0);
      addr = {1'($urandom_range(1, 0)), 31'($urandom)};
      if (addr[31]) addr[AW+1:2] = AW'($urandom_range(23, 0));
      bus.if_addr  = addr;
      bus.if_stall = st;
      bus.if_flush = fl;
      if (fl)       exp = {NOP, 1'b0, 1'b0};
      else if (!st) exp = exp_fetch(addr);
      step();
      checks++;
      if ({bus.if_instr, bus.if_valid, bus.if_fault} !== exp) begin
        errors++;
        $display("FAIL rnd_fetch%0d addr=%h st=%b fl=%b: got %h/%b/%b expected %h/%b/%b",
                 n, addr, st, fl, bus.if_instr, bus.if_valid, bus.if_fault,
                 exp[33:2], exp[1], exp[0]);
      end
    end
    bus.if_stall = 1'b0;
    bus.if_flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (user_m[i]) user_m[i] = NOP;
    foreach (kern_m[i]) kern_m[i] = NOP;
    reset        = 1'b0;
    bus.if_addr  = '0;
    bus.if_stall = 1'b0;
    bus.if_flush = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_bank  = 1'b0;
    bus.ld_base  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;

    test_reset();
    test_user_load();
    test_kernel_load();
    test_fault();
    test_stall_flush();
    test_overflow();
    test_reset_mid_load();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
